// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : State and owner encodings shared by the memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_t;

    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    function automatic logic other_owner(input logic owner);
        return (owner == OWN_C) ? OWN_D : OWN_C;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb_pick
// Brief   : Combinational winner select between core (C) and DMA (D) ports.
// Revision: 1.0 - initial release
// ============================================================================
module arb_pick #(
    parameter int PRIO_CORE = 1
) (
    input  logic c_req,
    input  logic d_req,
    input  logic last_owner,
    output logic win
);
    import mem_port_arbiter_pkg::*;

    logic w_tie_win;

    // A tie goes either to the core unconditionally or to whoever did not win last.
    generate
        if (PRIO_CORE != 0) begin : g_prio_core
            assign w_tie_win = OWN_C;
        end else begin : g_round_robin
            assign w_tie_win = other_owner(last_owner);
        end
    endgenerate

    always_comb begin
        win = OWN_C;
        if (c_req && d_req) begin
            win = w_tie_win;
        end else if (d_req) begin
            win = OWN_D;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares a fixed-latency single-port memory between core and DMA ports.
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_LAT   = 2,
    parameter int PRIO_CORE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);
    import mem_port_arbiter_pkg::*;

    localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [DW-1:0]    r_wdata;
    logic             r_c_gnt;
    logic             r_d_gnt;
    logic [DW-1:0]    r_c_rdata;
    logic [DW-1:0]    r_d_rdata;
    logic             w_win;
    logic             w_grant;
    logic             w_in_access;
    logic             w_capture;

    arb_pick #(
        .PRIO_CORE (PRIO_CORE)
    ) u_arb_pick (
        .c_req      (c_req),
        .d_req      (d_req),
        .last_owner (r_last_owner),
        .win        (w_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_in_access = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (c_req || d_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                w_in_access = 1'b1;
                if (r_cnt == '0) begin
                    w_capture   = ~r_we;
                    w_state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase

        // The memory bus is driven only while an access is in flight.
        mem_addr  = w_in_access ? r_addr  : '0;
        mem_wdata = w_in_access ? r_wdata : '0;
        mem_read  = w_in_access & ~r_we;
        mem_write = w_in_access &  r_we;
        c_done    = (r_state == ARB_DONE) && (r_owner == OWN_C);
        d_done    = (r_state == ARB_DONE) && (r_owner == OWN_D);
        busy      = (r_state != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_owner      <= OWN_C;
            r_last_owner <= OWN_D;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_c_gnt      <= 1'b0;
            r_d_gnt      <= 1'b0;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_c_gnt <= w_grant && (w_win == OWN_C);
            r_d_gnt <= w_grant && (w_win == OWN_D);
            if (w_grant) begin
                r_owner      <= w_win;
                r_last_owner <= w_win;
                r_cnt        <= CNT_LOAD;
                if (w_win == OWN_C) begin
                    r_we    <= c_we;
                    r_addr  <= c_addr;
                    r_wdata <= c_wdata;
                end else begin
                    r_we    <= d_we;
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                end
            end else if (w_in_access && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Read data lands on the last strobe cycle and is kept until the owner's next read.
            if (w_capture) begin
                if (r_owner == OWN_C) begin
                    r_c_rdata <= mem_rdata;
                end else begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign c_gnt   = r_c_gnt;
    assign d_gnt   = r_d_gnt;
    assign c_rdata = r_c_rdata;
    assign d_rdata = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Directed self-checking bench for mem_port_arbiter (three configurations).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: MEM_LAT=2, PRIO_CORE=1
    logic        a_rst = 1'b1;
    logic        a_c_req = 0, a_c_we = 0, a_d_req = 0, a_d_we = 0;
    logic [31:0] a_c_addr = 0, a_c_wdata = 0, a_d_addr = 0, a_d_wdata = 0;
    logic        a_c_gnt, a_c_done, a_d_gnt, a_d_done, a_mem_read, a_mem_write, a_busy;
    logic [31:0] a_c_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    assign a_mem_rdata = 32'hA5A5_0000 | {16'h0, a_mem_addr[15:0]};

    // Instance B: MEM_LAT=2, PRIO_CORE=0
    logic        b_rst = 1'b1;
    logic        b_c_req = 0, b_c_we = 0, b_d_req = 0, b_d_we = 0;
    logic [31:0] b_c_addr = 0, b_c_wdata = 0, b_d_addr = 0, b_d_wdata = 0;
    logic        b_c_gnt, b_c_done, b_d_gnt, b_d_done, b_mem_read, b_mem_write, b_busy;
    logic [31:0] b_c_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    assign b_mem_rdata = 32'hA5A5_0000 | {16'h0, b_mem_addr[15:0]};

    // Instance L: MEM_LAT=1, PRIO_CORE=1
    logic        l_rst = 1'b1;
    logic        l_c_req = 0, l_c_we = 0, l_d_req = 0, l_d_we = 0;
    logic [31:0] l_c_addr = 0, l_c_wdata = 0, l_d_addr = 0, l_d_wdata = 0;
    logic        l_c_gnt, l_c_done, l_d_gnt, l_d_done, l_mem_read, l_mem_write, l_busy;
    logic [31:0] l_c_rdata, l_d_rdata, l_mem_addr, l_mem_wdata, l_mem_rdata;
    assign l_mem_rdata = 32'hA5A5_0000 | {16'h0, l_mem_addr[15:0]};

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .PRIO_CORE(1)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .c_req(a_c_req), .c_we(a_c_we), .c_addr(a_c_addr), .c_wdata(a_c_wdata),
        .c_gnt(a_c_gnt), .c_done(a_c_done), .c_rdata(a_c_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_done(a_d_done), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_read(a_mem_read),
        .mem_write(a_mem_write), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .PRIO_CORE(0)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
        .c_gnt(b_c_gnt), .c_done(b_c_done), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_done(b_d_done), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .PRIO_CORE(1)) u_dut_l (
        .clk(clk), .rst(l_rst),
        .c_req(l_c_req), .c_we(l_c_we), .c_addr(l_c_addr), .c_wdata(l_c_wdata),
        .c_gnt(l_c_gnt), .c_done(l_c_done), .c_rdata(l_c_rdata),
        .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
        .d_gnt(l_d_gnt), .d_done(l_d_done), .d_rdata(l_d_rdata),
        .mem_addr(l_mem_addr), .mem_wdata(l_mem_wdata), .mem_read(l_mem_read),
        .mem_write(l_mem_write), .mem_rdata(l_mem_rdata), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Advance to just after the next rising edge; all checks and input changes happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        a_rst = 1'b0; b_rst = 1'b0; l_rst = 1'b0;
        chk1("rst_c_gnt", a_c_gnt, 1'b0);
        chk1("rst_d_gnt", a_d_gnt, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_mem_read", a_mem_read, 1'b0);
        chk1("rst_mem_write", a_mem_write, 1'b0);
        chk("rst_mem_addr", a_mem_addr, 32'h0);
        chk("rst_c_rdata", a_c_rdata, 32'h0);
        chk("rst_d_rdata", a_d_rdata, 32'h0);

        // 1: core read of 0x10
        a_c_req = 1; a_c_we = 0; a_c_addr = 32'h10;
        tick();
        chk1("t1_c1_gnt", a_c_gnt, 1'b1);
        chk1("t1_c1_read", a_mem_read, 1'b1);
        chk("t1_c1_addr", a_mem_addr, 32'h10);
        chk1("t1_c1_busy", a_busy, 1'b1);
        chk1("t1_c1_done", a_c_done, 1'b0);
        a_c_req = 0;
        tick();
        chk1("t1_c2_gnt", a_c_gnt, 1'b0);
        chk1("t1_c2_read", a_mem_read, 1'b1);
        tick();
        chk1("t1_c3_done", a_c_done, 1'b1);
        chk1("t1_c3_read", a_mem_read, 1'b0);
        chk("t1_c3_rdata", a_c_rdata, 32'hA5A5_0010);
        chk("t1_c3_addr", a_mem_addr, 32'h0);
        tick();
        chk1("t1_c4_done", a_c_done, 1'b0);
        chk1("t1_c4_busy", a_busy, 1'b0);

        // 2: DMA write of 0xDEADBEEF to 0x20
        a_d_req = 1; a_d_we = 1; a_d_addr = 32'h20; a_d_wdata = 32'hDEAD_BEEF;
        tick();
        chk1("t2_c1_gnt", a_d_gnt, 1'b1);
        chk1("t2_c1_cgnt", a_c_gnt, 1'b0);
        chk1("t2_c1_write", a_mem_write, 1'b1);
        chk1("t2_c1_read", a_mem_read, 1'b0);
        chk("t2_c1_addr", a_mem_addr, 32'h20);
        chk("t2_c1_wdata", a_mem_wdata, 32'hDEAD_BEEF);
        a_d_req = 0;
        tick();
        chk1("t2_c2_write", a_mem_write, 1'b1);
        tick();
        chk1("t2_c3_done", a_d_done, 1'b1);
        chk1("t2_c3_cdone", a_c_done, 1'b0);
        chk1("t2_c3_write", a_mem_write, 1'b0);
        chk("t2_c3_drdata", a_d_rdata, 32'h0);
        chk("t2_c3_crdata", a_c_rdata, 32'hA5A5_0010);
        tick();

        // 3: simultaneous requests, core priority
        a_c_req = 1; a_c_we = 0; a_c_addr = 32'h30;
        a_d_req = 1; a_d_we = 0; a_d_addr = 32'h40;
        tick();
        chk1("t3_c1_cgnt", a_c_gnt, 1'b1);
        chk1("t3_c1_dgnt", a_d_gnt, 1'b0);
        chk("t3_c1_addr", a_mem_addr, 32'h30);
        a_c_req = 0;
        tick();
        tick();
        chk1("t3_c3_cdone", a_c_done, 1'b1);
        chk1("t3_c3_cgnt", a_c_gnt, 1'b0);
        chk1("t3_c3_ddone", a_d_done, 1'b0);
        chk("t3_c3_crdata", a_c_rdata, 32'hA5A5_0030);
        tick();
        chk1("t3_c4_busy", a_busy, 1'b0);
        chk1("t3_c4_dgnt", a_d_gnt, 1'b0);
        tick();
        chk1("t3_c5_dgnt", a_d_gnt, 1'b1);
        chk("t3_c5_addr", a_mem_addr, 32'h40);
        a_d_req = 0;
        tick();
        tick();
        chk1("t3_c7_ddone", a_d_done, 1'b1);
        chk1("t3_c7_dgnt", a_d_gnt, 1'b0);
        chk("t3_c7_drdata", a_d_rdata, 32'hA5A5_0040);
        chk("t3_c7_crdata", a_c_rdata, 32'hA5A5_0030);
        tick();

        // 5: reset during the second access cycle of a core read
        a_c_req = 1; a_c_we = 0; a_c_addr = 32'h50;
        tick();
        chk1("t5_c1_gnt", a_c_gnt, 1'b1);
        a_c_req = 0;
        tick();
        chk1("t5_c2_read", a_mem_read, 1'b1);
        a_rst = 1;
        tick();
        a_rst = 0;
        chk1("t5_c3_done", a_c_done, 1'b0);
        chk1("t5_c3_read", a_mem_read, 1'b0);
        chk1("t5_c3_busy", a_busy, 1'b0);
        chk("t5_c3_addr", a_mem_addr, 32'h0);
        chk("t5_c3_crdata", a_c_rdata, 32'h0);
        a_c_req = 1; a_c_addr = 32'h60;
        tick();
        chk1("t5_r1_gnt", a_c_gnt, 1'b1);
        a_c_req = 0;
        tick();
        tick();
        chk1("t5_r3_done", a_c_done, 1'b1);
        chk("t5_r3_crdata", a_c_rdata, 32'hA5A5_0060);
        tick();

        // 4: round-robin with both ports holding their requests
        b_c_req = 1; b_c_addr = 32'h100;
        b_d_req = 1; b_d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("t4_cgnt", b_c_gnt, (k % 2) == 0);
            chk1("t4_dgnt", b_d_gnt, (k % 2) == 1);
            chk("t4_addr", b_mem_addr, ((k % 2) == 0) ? 32'h100 : 32'h200);
            tick();
            tick();
            chk1("t4_cdone", b_c_done, (k % 2) == 0);
            chk1("t4_ddone", b_d_done, (k % 2) == 1);
            tick();
        end
        b_c_req = 0; b_d_req = 0;

        // 6: MEM_LAT=1, core read then write back-to-back
        l_c_req = 1; l_c_we = 0; l_c_addr = 32'h70;
        tick();
        chk1("t6_c1_gnt", l_c_gnt, 1'b1);
        chk1("t6_c1_read", l_mem_read, 1'b1);
        l_c_we = 1; l_c_addr = 32'h74; l_c_wdata = 32'h1234_5678;
        tick();
        chk1("t6_c2_done", l_c_done, 1'b1);
        chk1("t6_c2_read", l_mem_read, 1'b0);
        chk("t6_c2_rdata", l_c_rdata, 32'hA5A5_0070);
        tick();
        chk1("t6_c3_done", l_c_done, 1'b0);
        chk1("t6_c3_read", l_mem_read, 1'b0);
        chk1("t6_c3_write", l_mem_write, 1'b0);
        tick();
        chk1("t6_c4_gnt", l_c_gnt, 1'b1);
        chk1("t6_c4_write", l_mem_write, 1'b1);
        chk("t6_c4_wdata", l_mem_wdata, 32'h1234_5678);
        chk("t6_c4_addr", l_mem_addr, 32'h74);
        l_c_req = 0;
        tick();
        chk1("t6_c5_done", l_c_done, 1'b1);
        chk1("t6_c5_write", l_mem_write, 1'b0);
        chk("t6_c5_rdata", l_c_rdata, 32'hA5A5_0070);
        tick();
        chk1("t6_c6_busy", l_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
